// File: rtl/m68k_pkg.sv
// m68k_pkg -- device codes, bus-cycle state encoding and default wait states
// shared by the 68000 CPLD decode/acknowledge logic. Rev 1.0
`default_nettype none

package m68k_pkg;

  localparam logic [3:0] DEV_NONE   = 4'd0;
  localparam logic [3:0] DEV_EEPROM = 4'd1;
  localparam logic [3:0] DEV_RAM    = 4'd2;
  localparam logic [3:0] DEV_OTHER  = 4'd3;

  localparam int DEF_EEPROM_WS = 2;
  localparam int DEF_RAM_WS    = 0;
  localparam int DEF_TIMEOUT   = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } bus_state_e;

  // Codes outside the known set get no wait states; they are treated as NONE.
  function automatic logic [3:0] ws_for_dev(input logic [3:0] dev,
                                            input logic [3:0] eeprom_ws,
                                            input logic [3:0] ram_ws);
    case (dev)
      DEV_EEPROM: return eeprom_ws;
      DEV_RAM:    return ram_ws;
      default:    return 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/m68k_sync2.sv
// m68k_sync2 -- two-flop synchroniser, asynchronous active-high reset to 0. Rev 1.0
`default_nettype none

module m68k_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/m68k_dtack_gen.sv
// m68k_dtack_gen -- DTACK/BERR generator with per-device wait states; bus-error
// timeout and NONE-device errors enabled by M68K_BERR_TIMEOUT_EN. Rev 1.0
`default_nettype none

module m68k_dtack_gen
  import m68k_pkg::*;
#(
  parameter int EEPROM_WS = DEF_EEPROM_WS,
  parameter int RAM_WS    = DEF_RAM_WS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk16,
  input  logic       reset,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic       rw,
  input  logic [3:0] cs,
  input  logic       dtack_trig,
  output logic       dtack_n,
  output logic       berr_n,
  output logic       cycle_rd
);

  generate
    if (TIMEOUT < 1 || TIMEOUT > 127) begin : g_bad_timeout
      $error("m68k_dtack_gen: TIMEOUT must be 1..127");
    end
    if (EEPROM_WS < 0 || EEPROM_WS > 15 || RAM_WS < 0 || RAM_WS > 15) begin : g_bad_ws
      $error("m68k_dtack_gen: wait states must be 0..15");
    end
  endgenerate

  bus_state_e state_q, state_d;
  logic [3:0] ws_cnt_q, ws_cnt_d;
  logic [3:0] cs_q, cs_d;
  logic       cycle_rd_q, cycle_rd_d;
  logic       dtack_n_q;
  logic       trig_sync;
  logic       strobe_low;
  logic       ack_ok;

  m68k_sync2 u_trig_sync (
    .clk_i (clk16),
    .rst_i (reset),
    .d_i   (dtack_trig),
    .q_o   (trig_sync)
  );

  assign strobe_low = ~(uds_n & lds_n);

`ifdef M68K_BERR_TIMEOUT_EN
  logic [6:0] to_cnt_q, to_cnt_d;
  logic       berr_n_q;
  logic       err_now;
`endif

  always_comb begin
    ack_ok = 1'b0;
    case (cs_q)
      DEV_EEPROM, DEV_RAM: ack_ok = (ws_cnt_q == 4'd0) && strobe_low;
      DEV_OTHER:           ack_ok = trig_sync && strobe_low;
`ifdef M68K_BERR_TIMEOUT_EN
      default:             ack_ok = 1'b0;
`else
      default:             ack_ok = (ws_cnt_q == 4'd0) && strobe_low;
`endif
    endcase
  end

`ifdef M68K_BERR_TIMEOUT_EN
  // Unknown device codes error out immediately, like NONE.
  assign err_now = (cs_q != DEV_EEPROM && cs_q != DEV_RAM && cs_q != DEV_OTHER) ||
                   (to_cnt_q == 7'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d    = state_q;
    ws_cnt_d   = ws_cnt_q;
    cs_d       = cs_q;
    cycle_rd_d = cycle_rd_q;
`ifdef M68K_BERR_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef M68K_BERR_TIMEOUT_EN
        to_cnt_d = 7'd0;
`endif
        if (!as_n) begin
          state_d    = ST_WAIT;
          cs_d       = cs;
          cycle_rd_d = rw;
          ws_cnt_d   = ws_for_dev(cs, 4'(EEPROM_WS), 4'(RAM_WS));
        end
      end
      ST_WAIT: begin
        if (ws_cnt_q != 4'd0) ws_cnt_d = ws_cnt_q - 4'd1;
`ifdef M68K_BERR_TIMEOUT_EN
        if (to_cnt_q != 7'h7F) to_cnt_d = to_cnt_q + 7'd1;
`endif
        // Abort beats acknowledge; acknowledge beats timeout on the same edge.
        if (as_n)        state_d = ST_IDLE;
        else if (ack_ok) state_d = ST_ACK;
`ifdef M68K_BERR_TIMEOUT_EN
        else if (err_now) state_d = ST_ERR;
`endif
      end
      ST_ACK: begin
        if (as_n) state_d = ST_IDLE;
      end
`ifdef M68K_BERR_TIMEOUT_EN
      ST_ERR: begin
        if (as_n) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ws_cnt_q   <= 4'd0;
      cs_q       <= DEV_NONE;
      cycle_rd_q <= 1'b1;
      dtack_n_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      ws_cnt_q   <= ws_cnt_d;
      cs_q       <= cs_d;
      cycle_rd_q <= cycle_rd_d;
      dtack_n_q  <= (state_d != ST_ACK);
    end
  end

`ifdef M68K_BERR_TIMEOUT_EN
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      to_cnt_q <= 7'd0;
      berr_n_q <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_d;
      berr_n_q <= (state_d != ST_ERR);
    end
  end

  assign berr_n = berr_n_q;
`else
  assign berr_n = 1'b1;
`endif

  assign dtack_n  = dtack_n_q;
  assign cycle_rd = cycle_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_m68k_dtack_gen.sv
// tb_m68k_dtack_gen -- randomized and directed bus cycles checked against an
// edge-index model of when DTACK/BERR must assert. Rev 1.0
`default_nettype none

module tb_m68k_dtack_gen;
  import m68k_pkg::*;

  localparam int EWS   = 2;
  localparam int RWS   = 0;
  localparam int TOUT  = 100;
  localparam int NEVER = 100000;

  logic       clk16 = 1'b0;
  logic       reset = 1'b1;
  logic       as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [3:0] cs = 4'd0;
  logic       dtack_trig = 1'b0;
  logic       dtack_n, berr_n, cycle_rd;

  int checks = 0;
  int errors = 0;

  m68k_dtack_gen #(.EEPROM_WS(EWS), .RAM_WS(RWS), .TIMEOUT(TOUT)) dut (
    .clk16      (clk16),
    .reset      (reset),
    .as_n       (as_n),
    .uds_n      (uds_n),
    .lds_n      (lds_n),
    .rw         (rw),
    .cs         (cs),
    .dtack_trig (dtack_trig),
    .dtack_n    (dtack_n),
    .berr_n     (berr_n),
    .cycle_rd   (cycle_rd)
  );

  always #5 clk16 = ~clk16;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Outcome of a cycle whose as_n low is sampled at edge E0. es: first edge
  // sampling a data strobe low; et: first edge sampling dtack_trig high.
  // kind 0 = nothing, 1 = DTACK, 2 = BERR; kout = edge after which it asserts.
  task automatic predict(input logic [3:0] dev, input int es, input int et,
                         output int kind, output int kout);
    int ws, k_ack;
    ws = (dev == DEV_EEPROM) ? EWS : (dev == DEV_RAM) ? RWS : 0;
    if (dev == DEV_OTHER)
      k_ack = (et >= NEVER) ? NEVER : imax(imax(et + 2, es), 1);
    else
      k_ack = imax(1 + ws, es);
`ifdef M68K_BERR_TIMEOUT_EN
    if (dev != DEV_EEPROM && dev != DEV_RAM && dev != DEV_OTHER) begin
      kind = 2; kout = 1;
    end else if (k_ack <= TOUT) begin
      kind = 1; kout = k_ack;
    end else begin
      kind = 2; kout = TOUT;
    end
`else
    if (k_ack < NEVER) begin kind = 1; kout = k_ack; end
    else begin kind = 0; kout = NEVER; end
`endif
  endtask

  task automatic idle_edges(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk16);
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; dtack_trig = 1'b0;
      @(negedge clk16);
      check({tag, ":idle_dtack"}, dtack_n, 1'b1);
      check({tag, ":idle_berr"}, berr_n, 1'b1);
    end
  endtask

  // One bus cycle. abort_at > 0 forces as_n high to be sampled at that edge.
  task automatic run_txn(input logic [3:0] dev, input int es, input int et,
                         input int abort_at, input logic rwv, input string tag);
    int kind, kout, ea, which;
    predict(dev, es, et, kind, kout);
    if (abort_at > 0)   ea = abort_at;
    else if (kind != 0) ea = kout + 1 + int'($urandom_range(0, 2));
    else                ea = 6 + int'($urandom_range(0, 6));
    which = int'($urandom_range(0, 2));
    for (int k = 0; k <= ea + 1; k++) begin
      @(negedge clk16);
      if (k >= 1) begin
        check($sformatf("%s:dtack@E%0d", tag, k - 1), dtack_n,
              !(kind == 1 && kout <= k - 1 && k - 1 < ea));
        check($sformatf("%s:berr@E%0d", tag, k - 1), berr_n,
              !(kind == 2 && kout <= k - 1 && k - 1 < ea));
        if (k == 1 || k == ea + 1)
          check($sformatf("%s:cycle_rd@E%0d", tag, k - 1), cycle_rd, rwv);
      end
      as_n       = (k >= ea);
      uds_n      = !(k >= es && k < ea && which != 1);
      lds_n      = !(k >= es && k < ea && which != 0);
      dtack_trig = (k >= et && k < ea);
      if (k == 0) begin cs = dev; rw = rwv; end
      else begin cs = 4'($urandom_range(0, 3)); rw = 1'($urandom); end
    end
    idle_edges(3, tag);
  endtask

  initial begin
    int dev, es, et, ab;
    #12;
    check("reset:dtack", dtack_n, 1'b1);
    check("reset:berr", berr_n, 1'b1);
    check("reset:cycle_rd", cycle_rd, 1'b1);
    @(negedge clk16);
    reset = 1'b0;
    idle_edges(2, "post_reset");

    run_txn(DEV_RAM,    0, NEVER, 0, 1'b1, "ram_rd");
    run_txn(DEV_EEPROM, 3, NEVER, 0, 1'b0, "eeprom_wr_lag");
    run_txn(DEV_EEPROM, 0, NEVER, 0, 1'b1, "eeprom_rd");
    run_txn(DEV_OTHER,  0, 5,     0, 1'b1, "other_trig5");
    run_txn(DEV_OTHER,  0, NEVER, 0, 1'b1, "other_timeout");
    run_txn(DEV_OTHER,  0, TOUT - 2, 0, 1'b0, "other_tie");
    run_txn(DEV_EEPROM, 0, NEVER, 1, 1'b1, "eeprom_abort");
    run_txn(DEV_NONE,   0, NEVER, 0, 1'b1, "none_dev");

    // Asynchronous reset while acknowledging a RAM cycle.
    @(negedge clk16);
    as_n = 1'b0; lds_n = 1'b0; cs = DEV_RAM; rw = 1'b0;
    @(negedge clk16);
    @(negedge clk16);
    check("rst_in_ack:pre_dtack", dtack_n, 1'b0);
    #2 reset = 1'b1; as_n = 1'b1; lds_n = 1'b1;
    #1;
    check("rst_in_ack:dtack", dtack_n, 1'b1);
    check("rst_in_ack:berr", berr_n, 1'b1);
    check("rst_in_ack:cycle_rd", cycle_rd, 1'b1);
    @(negedge clk16);
    reset = 1'b0;
    idle_edges(1, "rst_release");
    run_txn(DEV_RAM, 1, NEVER, 0, 1'b0, "ram_after_rst");

    for (int t = 0; t < 24; t++) begin
      dev = int'($urandom_range(0, 3));
      es  = int'($urandom_range(0, 5));
      et  = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 8));
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_txn(4'(dev), es, et, ab, 1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
